// File: rtl/jesd204_rx_link_seq_64b.sv
// JESD204 RX link bring-up sequencer: walks PHY reset, link reset, lock wait,
// elastic-buffer release and run-time supervision, with bounded retries.
module jesd204_rx_link_seq_64b #(
    parameter int TIMEOUT_WIDTH     = 16,
    parameter int PHY_RESET_CYCLES  = 16,
    parameter int LINK_RESET_CYCLES = 4,
    parameter int BACKOFF_CYCLES    = 64
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     cfg_enable,
    input  logic [TIMEOUT_WIDTH-1:0] cfg_timeout,
    input  logic [7:0]               cfg_release_delay,
    input  logic [3:0]               cfg_max_retries,
    input  logic [1:0]               link_state,
    input  logic                     all_emb_lock,
    input  logic                     event_unexpected_lane_state_error,
    output logic                     phy_reset,
    output logic                     link_reset,
    output logic                     buffer_release_n,
    output logic [2:0]               status_seq_state,
    output logic [3:0]               status_retry_count,
    output logic                     status_link_up,
    output logic                     status_failed,
    output logic                     event_retry
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PHY_RESET  = 3'd1,
        ST_LINK_RESET = 3'd2,
        ST_WAIT_LOCK  = 3'd3,
        ST_RELEASE    = 3'd4,
        ST_RUNNING    = 3'd5,
        ST_BACKOFF    = 3'd6,
        ST_FAILED     = 3'd7
    } state_t;

    // Phase counter is loaded with (cycles - 1) so each timed state lasts exactly N cycles.
    localparam int               CNT_W     = 16;
    localparam logic [CNT_W-1:0] L_PHY     = CNT_W'(PHY_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_LINK    = CNT_W'(LINK_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_BACKOFF = CNT_W'(BACKOFF_CYCLES - 1);

    localparam logic [1:0] LS_BLOCK_SYNC = 2'b10;
    localparam logic [1:0] LS_DATA       = 2'b11;

    state_t                   r_state;
    logic [CNT_W-1:0]         r_phase_cnt;
    logic [TIMEOUT_WIDTH-1:0] r_timer;
    logic [7:0]               r_delay;
    logic [3:0]               r_retry;
    logic                     r_data_seen;
    logic [3:0]               r_outs;       // {phy_reset, link_reset, buffer_release_n, status_failed}
    logic                     r_link_up;
    logic                     r_event_retry;

    logic w_locked;
    logic w_timer_zero;
    logic w_wait_fail;
    logic w_run_fail;
    logic w_fail;
    logic w_exhausted;

    // Static output levels implied by a given state.
    function automatic logic [3:0] out_dec(input state_t s);
        logic phy;
        logic lnk;
        logic bufn;
        logic fail;
        phy  = (s == ST_IDLE) || (s == ST_PHY_RESET) || (s == ST_FAILED);
        lnk  = phy || (s == ST_LINK_RESET) || (s == ST_BACKOFF);
        bufn = (s != ST_RUNNING);
        fail = (s == ST_FAILED);
        return {phy, lnk, bufn, fail};
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    assign w_locked     = (link_state == LS_BLOCK_SYNC) && all_emb_lock;
    assign w_timer_zero = (r_timer == '0);
    assign w_wait_fail  = (r_state == ST_WAIT_LOCK) && !w_locked && w_timer_zero;
    // Error and timeout in the same cycle collapse into one failure event.
    assign w_run_fail   = (r_state == ST_RUNNING) &&
                          (event_unexpected_lane_state_error || !link_state[1] ||
                           ((link_state == LS_BLOCK_SYNC) && !r_data_seen && w_timer_zero));
    assign w_fail       = w_wait_fail || w_run_fail;
    assign w_exhausted  = (r_retry == cfg_max_retries);

    // Sequencer state, counters and registered outputs, all updated on the same edge.
    always_ff @(posedge clk) begin
        if (!resetn || !cfg_enable) begin
            r_state       <= ST_IDLE;
            r_outs        <= out_dec(ST_IDLE);
            r_phase_cnt   <= '0;
            r_timer       <= '0;
            r_delay       <= '0;
            r_retry       <= '0;
            r_data_seen   <= 1'b0;
            r_link_up     <= 1'b0;
            r_event_retry <= 1'b0;
        end else begin
            r_link_up     <= 1'b0;
            r_event_retry <= 1'b0;
            if (w_fail) begin
                if (w_exhausted) begin
                    r_state <= ST_FAILED;
                    r_outs  <= out_dec(ST_FAILED);
                end else begin
                    r_state       <= ST_BACKOFF;
                    r_outs        <= out_dec(ST_BACKOFF);
                    r_phase_cnt   <= L_BACKOFF;
                    r_retry       <= sat_inc(r_retry);
                    r_event_retry <= 1'b1;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state     <= ST_PHY_RESET;
                        r_outs      <= out_dec(ST_PHY_RESET);
                        r_phase_cnt <= L_PHY;
                        r_retry     <= '0;
                    end
                    ST_PHY_RESET: begin
                        if (r_phase_cnt == '0) begin
                            r_state     <= ST_LINK_RESET;
                            r_outs      <= out_dec(ST_LINK_RESET);
                            r_phase_cnt <= L_LINK;
                        end else begin
                            r_phase_cnt <= r_phase_cnt - CNT_W'(1);
                        end
                    end
                    ST_LINK_RESET: begin
                        if (r_phase_cnt == '0) begin
                            r_state <= ST_WAIT_LOCK;
                            r_outs  <= out_dec(ST_WAIT_LOCK);
                            r_timer <= cfg_timeout;
                        end else begin
                            r_phase_cnt <= r_phase_cnt - CNT_W'(1);
                        end
                    end
                    ST_WAIT_LOCK: begin
                        if (w_locked) begin
                            r_state <= ST_RELEASE;
                            r_outs  <= out_dec(ST_RELEASE);
                            r_delay <= cfg_release_delay;
                        end else begin
                            r_timer <= r_timer - TIMEOUT_WIDTH'(1);
                        end
                    end
                    ST_RELEASE: begin
                        if (!w_locked) begin
                            r_state <= ST_WAIT_LOCK;
                            r_outs  <= out_dec(ST_WAIT_LOCK);
                            r_timer <= cfg_timeout;
                        end else if (r_delay == 8'd0) begin
                            r_state     <= ST_RUNNING;
                            r_outs      <= out_dec(ST_RUNNING);
                            r_timer     <= cfg_timeout;
                            r_data_seen <= 1'b0;
                        end else begin
                            r_delay <= r_delay - 8'd1;
                        end
                    end
                    ST_RUNNING: begin
                        // Once DATA has been observed the timeout stays disarmed.
                        if (link_state == LS_DATA) begin
                            r_data_seen <= 1'b1;
                            r_link_up   <= 1'b1;
                        end else if (!r_data_seen) begin
                            r_timer <= r_timer - TIMEOUT_WIDTH'(1);
                        end
                    end
                    ST_BACKOFF: begin
                        if (r_phase_cnt == '0) begin
                            r_state     <= ST_PHY_RESET;
                            r_outs      <= out_dec(ST_PHY_RESET);
                            r_phase_cnt <= L_PHY;
                        end else begin
                            r_phase_cnt <= r_phase_cnt - CNT_W'(1);
                        end
                    end
                    ST_FAILED: begin
                        r_state <= ST_FAILED;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_outs  <= out_dec(ST_IDLE);
                    end
                endcase
            end
        end
    end

    assign {phy_reset, link_reset, buffer_release_n, status_failed} = r_outs;
    assign status_seq_state   = r_state;
    assign status_retry_count = r_retry;
    assign status_link_up     = r_link_up;
    assign event_retry        = r_event_retry;

endmodule

// File: tb/tb_jesd204_rx_link_seq_64b.sv
// Bench for the JESD204 RX link sequencer: a cycle model pushes the expected
// output vector per clock into a scoreboard queue, popped after each edge.
module tb_jesd204_rx_link_seq_64b;

    localparam int PHY_CYC  = 16;
    localparam int LINK_CYC = 4;
    localparam int BACK_CYC = 64;
    localparam logic [12:0] RST_VEC = 13'b000_0000_111000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cfg_enable;
    logic [15:0] cfg_timeout;
    logic [7:0]  cfg_release_delay;
    logic [3:0]  cfg_max_retries;
    logic [1:0]  link_state;
    logic        all_emb_lock;
    logic        lane_err;
    logic        phy_reset;
    logic        link_reset;
    logic        buffer_release_n;
    logic [2:0]  status_seq_state;
    logic [3:0]  status_retry_count;
    logic        status_link_up;
    logic        status_failed;
    logic        event_retry;

    jesd204_rx_link_seq_64b #(
        .TIMEOUT_WIDTH    (16),
        .PHY_RESET_CYCLES (PHY_CYC),
        .LINK_RESET_CYCLES(LINK_CYC),
        .BACKOFF_CYCLES   (BACK_CYC)
    ) dut (
        .clk                              (clk),
        .resetn                           (resetn),
        .cfg_enable                       (cfg_enable),
        .cfg_timeout                      (cfg_timeout),
        .cfg_release_delay                (cfg_release_delay),
        .cfg_max_retries                  (cfg_max_retries),
        .link_state                       (link_state),
        .all_emb_lock                     (all_emb_lock),
        .event_unexpected_lane_state_error(lane_err),
        .phy_reset                        (phy_reset),
        .link_reset                       (link_reset),
        .buffer_release_n                 (buffer_release_n),
        .status_seq_state                 (status_seq_state),
        .status_retry_count               (status_retry_count),
        .status_link_up                   (status_link_up),
        .status_failed                    (status_failed),
        .event_retry                      (event_retry)
    );

    always #5 clk = ~clk;

    logic [12:0] w_dut_vec;
    assign w_dut_vec = {status_seq_state, status_retry_count, phy_reset, link_reset,
                        buffer_release_n, status_link_up, status_failed, event_retry};

    int          n_checks = 0;
    int          n_fail   = 0;
    int          evr_pulses = 0;
    logic [12:0] sb_q[$];

    // Reference model: counts cycles spent in each state upwards.
    int m_state = 0;
    int m_n     = 0;
    int m_retry = 0;
    bit m_seen  = 0;
    bit m_up    = 0;
    bit m_evr   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [12:0] model_vec();
        logic phy;
        logic lnk;
        logic bufn;
        logic fl;
        phy  = (m_state == 0) || (m_state == 1) || (m_state == 7);
        lnk  = phy || (m_state == 2) || (m_state == 6);
        bufn = (m_state != 5);
        fl   = (m_state == 7);
        return {3'(m_state), 4'(m_retry), phy, lnk, bufn, m_up, fl, m_evr};
    endfunction

    task automatic model_step();
        bit fail;
        bit locked;
        fail   = 0;
        m_up   = 0;
        m_evr  = 0;
        locked = (link_state == 2'b10) && all_emb_lock;
        if (!resetn || !cfg_enable) begin
            m_state = 0; m_n = 0; m_retry = 0; m_seen = 0;
        end else begin
            case (m_state)
                0: begin m_state = 1; m_n = 0; m_retry = 0; end
                1: if (m_n == PHY_CYC - 1) begin m_state = 2; m_n = 0; end else m_n++;
                2: if (m_n == LINK_CYC - 1) begin m_state = 3; m_n = 0; end else m_n++;
                3: if (locked) begin m_state = 4; m_n = 0; end
                   else if (m_n == int'(cfg_timeout)) fail = 1;
                   else m_n++;
                4: if (!locked) begin m_state = 3; m_n = 0; end
                   else if (m_n == int'(cfg_release_delay)) begin m_state = 5; m_n = 0; m_seen = 0; end
                   else m_n++;
                5: if (lane_err || link_state < 2'b10) fail = 1;
                   else if (link_state == 2'b11) begin m_seen = 1; m_up = 1; end
                   else if (!m_seen) begin
                       if (m_n == int'(cfg_timeout)) fail = 1; else m_n++;
                   end
                6: if (m_n == BACK_CYC - 1) begin m_state = 1; m_n = 0; end else m_n++;
                default: ;
            endcase
            if (fail) begin
                if (m_retry == int'(cfg_max_retries)) m_state = 7;
                else begin
                    m_state = 6; m_n = 0; m_evr = 1;
                    m_retry = (m_retry == 15) ? 15 : m_retry + 1;
                end
            end
        end
        sb_q.push_back(model_vec());
    endtask

    task automatic tick();
        logic [12:0] exp_v;
        model_step();
        @(posedge clk);
        #1;
        exp_v = sb_q.pop_front();
        chk("cyc", 32'(w_dut_vec), 32'(exp_v));
        if (event_retry === 1'b1) evr_pulses++;
    endtask

    task automatic dwell(input logic [2:0] st, input int budget, output int n);
        n = 0;
        while (status_seq_state == st && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
        int n;
        n = 0;
        while (status_seq_state != st && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(status_seq_state), 32'(st));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog t=%0t got=running exp=finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        resetn = 1'b0; cfg_enable = 1'b0; cfg_timeout = 16'd100;
        cfg_release_delay = 8'd3; cfg_max_retries = 4'd3;
        link_state = 2'b00; all_emb_lock = 1'b0; lane_err = 1'b0;
        repeat (3) tick();
        chk("rst_vec", 32'(w_dut_vec), 32'(RST_VEC));
        resetn = 1'b1;
        tick();
        chk("idle_hold", 32'(status_seq_state), 0);

        // Nominal bring-up
        cfg_enable = 1'b1;
        tick();
        chk("enter_phy", 32'(status_seq_state), 1);
        dwell(3'd1, 100, n);
        chk("phy_dwell", 32'(n), PHY_CYC);
        chk("phy_low", 32'(phy_reset), 0);
        dwell(3'd2, 100, n);
        chk("link_dwell", 32'(n), LINK_CYC);
        chk("link_low", 32'(link_reset), 0);
        repeat (3) tick();
        link_state = 2'b10; all_emb_lock = 1'b1;
        tick();
        chk("enter_rel", 32'(status_seq_state), 4);
        dwell(3'd4, 100, n);
        chk("rel_dwell", 32'(n), 4);
        chk("buf_rel", 32'(buffer_release_n), 0);
        repeat (2) tick();
        link_state = 2'b11;
        tick();
        chk("link_up", 32'(status_link_up), 1);
        link_state = 2'b10;
        repeat (120) tick();
        chk("no_tmo_after_data", 32'(status_seq_state), 5);
        link_state = 2'b11;
        tick();

        // Runtime error
        lane_err = 1'b1;
        tick();
        lane_err = 1'b0;
        chk("err_backoff", 32'(status_seq_state), 6);
        chk("err_bufn", 32'(buffer_release_n), 1);
        chk("err_up", 32'(status_link_up), 0);
        chk("err_evr", 32'(event_retry), 1);
        chk("err_retry", 32'(status_retry_count), 1);
        dwell(3'd6, 200, n);
        chk("backoff_dwell", 32'(n), BACK_CYC);
        chk("backoff_to_phy", 32'(status_seq_state), 1);

        // Lock loss during release
        cfg_release_delay = 8'd20; link_state = 2'b10; all_emb_lock = 1'b1;
        wait_state("reach_rel", 3'd4, 200);
        repeat (5) tick();
        all_emb_lock = 1'b0;
        tick();
        chk("lockloss_wait", 32'(status_seq_state), 3);
        chk("lockloss_bufn", 32'(buffer_release_n), 1);

        // Lock timeout
        cfg_enable = 1'b0;
        tick();
        chk("dis_vec", 32'(w_dut_vec), 32'(RST_VEC));
        cfg_timeout = 16'd10; link_state = 2'b01; cfg_enable = 1'b1;
        wait_state("reach_wait", 3'd3, 100);
        dwell(3'd3, 100, n);
        chk("wait_dwell", 32'(n), 11);
        chk("to_backoff", 32'(status_seq_state), 6);
        chk("to_evr", 32'(event_retry), 1);
        chk("to_retry", 32'(status_retry_count), 1);
        dwell(3'd6, 200, n);
        chk("to_backoff_dwell", 32'(n), BACK_CYC);
        chk("to_phy", 32'(status_seq_state), 1);

        // Retry exhaustion
        cfg_enable = 1'b0;
        tick();
        cfg_max_retries = 4'd2; cfg_enable = 1'b1; evr_pulses = 0;
        wait_state("reach_failed", 3'd7, 2000);
        chk("exh_pulses", 32'(evr_pulses), 2);
        chk("exh_failed", 32'(status_failed), 1);
        chk("exh_phy", 32'(phy_reset), 1);
        chk("exh_retry", 32'(status_retry_count), 2);
        repeat (5) tick();
        chk("failed_hold", 32'(status_seq_state), 7);
        cfg_enable = 1'b0;
        tick();
        chk("exh_idle", 32'(status_seq_state), 0);
        chk("exh_clear", 32'(status_failed), 0);

        // Zero retries with zero timeout
        cfg_max_retries = 4'd0; cfg_timeout = 16'd0; evr_pulses = 0; cfg_enable = 1'b1;
        wait_state("z_wait", 3'd3, 100);
        dwell(3'd3, 10, n);
        chk("z_dwell", 32'(n), 1);
        chk("z_failed", 32'(status_seq_state), 7);
        chk("z_evr", 32'(evr_pulses), 0);
        chk("z_retry", 32'(status_retry_count), 0);

        // Simultaneous error and run timeout
        cfg_enable = 1'b0;
        tick();
        cfg_max_retries = 4'd3; cfg_timeout = 16'd2; cfg_release_delay = 8'd0;
        link_state = 2'b10; all_emb_lock = 1'b1; cfg_enable = 1'b1;
        wait_state("s_run", 3'd5, 200);
        repeat (2) tick();
        evr_pulses = 0;
        lane_err = 1'b1;
        tick();
        lane_err = 1'b0;
        chk("s_backoff", 32'(status_seq_state), 6);
        repeat (3) tick();
        chk("s_pulses", 32'(evr_pulses), 1);
        chk("s_retry", 32'(status_retry_count), 1);

        // Abort mid PHY_RESET, then reset mid RUNNING
        cfg_enable = 1'b0;
        tick();
        cfg_enable = 1'b1;
        repeat (6) tick();
        chk("abort_in_phy", 32'(status_seq_state), 1);
        cfg_enable = 1'b0;
        tick();
        chk("abort_vec", 32'(w_dut_vec), 32'(RST_VEC));
        cfg_timeout = 16'd100; cfg_release_delay = 8'd3; cfg_enable = 1'b1;
        wait_state("r_run", 3'd5, 300);
        link_state = 2'b11;
        repeat (2) tick();
        chk("r_up", 32'(status_link_up), 1);
        resetn = 1'b0;
        tick();
        chk("rst_run_vec", 32'(w_dut_vec), 32'(RST_VEC));
        resetn = 1'b1; cfg_enable = 1'b0;
        repeat (3) tick();
        chk("rst_stay_idle", 32'(status_seq_state), 0);
        cfg_enable = 1'b1;
        tick();
        chk("rst_resume", 32'(status_seq_state), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jesd204_rx_link_seq_64b.md
JESD204_RX_LINK_SEQ_64B -- requirements
Module: jesd204_rx_link_seq_64b

Interface
REQ-001 SHALL have parameter TIMEOUT_WIDTH, default 16, width of the lock/data timeout counter.
REQ-002 SHALL have parameter PHY_RESET_CYCLES, default 16, number of cycles spent in PHY_RESET.
REQ-003 SHALL have parameter LINK_RESET_CYCLES, default 4, number of cycles spent in LINK_RESET.
REQ-004 SHALL have parameter BACKOFF_CYCLES, default 64, number of cycles spent in BACKOFF.
REQ-005 SHALL have port clk  input  1  single clock for all logic.
REQ-006 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port cfg_enable  input  1  link bring-up enable.
REQ-008 SHALL have port cfg_timeout  input  TIMEOUT_WIDTH  cycles allowed in WAIT_LOCK and for DATA to be reached in RUNNING.
REQ-009 SHALL have port cfg_release_delay  input  8  cycles from lock to buffer release.
REQ-010 SHALL have port cfg_max_retries  input  4  number of retries allowed before FAILED.
REQ-011 SHALL have port link_state  input  2  RX ctrl state: 00 reset, 01 wait_bs, 10 block_sync, 11 data.
REQ-012 SHALL have port all_emb_lock  input  1  all enabled lanes are multiblock-locked.
REQ-013 SHALL have port event_unexpected_lane_state_error  input  1  single-cycle error pulse from the RX ctrl.
REQ-014 SHALL have port phy_reset  output  1  PHY reset request, active-high.
REQ-015 SHALL have port link_reset  output  1  RX ctrl reset, active-high.
REQ-016 SHALL have port buffer_release_n  output  1  elastic buffer release, active-low.
REQ-017 SHALL have port status_seq_state  output  3  current sequencer state encoding.
REQ-018 SHALL have port status_retry_count  output  4  retries since leaving IDLE.
REQ-019 SHALL have port status_link_up  output  1  RUNNING with link_state == 11.
REQ-020 SHALL have port status_failed  output  1  sequencer is in FAILED.
REQ-021 SHALL have port event_retry  output  1  one-cycle pulse on each entry to BACKOFF.

Function
REQ-022 SHALL implement states IDLE=0, PHY_RESET=1, LINK_RESET=2, WAIT_LOCK=3, RELEASE=4, RUNNING=5, BACKOFF=6, FAILED=7, with status_seq_state equal to the state register.
REQ-023 SHALL register all outputs so that they reflect the new state on the same clock edge as the state update.
REQ-024 SHALL assert phy_reset in IDLE, PHY_RESET and FAILED, and deassert it in all other states.
REQ-025 SHALL assert link_reset in IDLE, PHY_RESET, LINK_RESET, BACKOFF and FAILED, and deassert it in all other states.
REQ-026 SHALL drive buffer_release_n = 0 only in RUNNING, and 1 in all other states.
REQ-027 SHALL force the state to IDLE on the next edge whenever cfg_enable = 0; this takes priority over every other transition.
REQ-028 IDLE: when cfg_enable = 1, SHALL go to PHY_RESET and clear the retry count.
REQ-029 PHY_RESET: SHALL stay exactly PHY_RESET_CYCLES cycles, then go to LINK_RESET.
REQ-030 LINK_RESET: SHALL stay exactly LINK_RESET_CYCLES cycles, then go to WAIT_LOCK with the timer loaded with cfg_timeout.
REQ-031 WAIT_LOCK: when link_state == 10 and all_emb_lock = 1, SHALL go to RELEASE with the delay counter loaded with cfg_release_delay.
REQ-032 WAIT_LOCK: otherwise, if the timer == 0, SHALL go to BACKOFF; otherwise the timer SHALL decrement. With cfg_timeout = 0, the failure occurs after 1 cycle.
REQ-033 RELEASE: if all_emb_lock = 0 or link_state != 10, SHALL return to WAIT_LOCK with the timer reloaded.
REQ-034 RELEASE: otherwise, if the delay counter == 0, SHALL go to RUNNING with the timer reloaded; otherwise the delay counter SHALL decrement.
REQ-035 RUNNING: on event_unexpected_lane_state_error = 1 or link_state ∈ {00, 01}, SHALL go to BACKOFF.
REQ-036 RUNNING: while link_state != 11, the timer SHALL decrement; at 0, SHALL go to BACKOFF.
REQ-037 RUNNING: once link_state == 11 is seen, the timeout SHALL be disabled until the state is left.
REQ-038 Entry to BACKOFF: if retry count == cfg_max_retries, SHALL go to FAILED instead; otherwise SHALL increment the retry count and pulse event_retry.
REQ-039 BACKOFF: SHALL stay exactly BACKOFF_CYCLES cycles, then go to PHY_RESET.
REQ-040 FAILED: SHALL hold status_failed = 1 and leave only via cfg_enable = 0.
REQ-041 Retry count: SHALL saturate at 15. With cfg_max_retries = 0, the first failure SHALL go directly to FAILED with no event_retry.
REQ-042 Simultaneous error and timeout in RUNNING SHALL produce a single BACKOFF entry.

Reset
REQ-043 When resetn = 0 at a clock edge, SHALL set state = IDLE, phy_reset = 1, link_reset = 1, buffer_release_n = 1, status_link_up = 0, status_failed = 0, event_retry = 0, retry count = 0, and all counters = 0.
REQ-044 Reset asserted in any state, including mid-count, SHALL restart from IDLE; bring-up resumes only with cfg_enable = 1 after reset is released.

Verification
REQ-045 Nominal bring-up: cfg_enable = 1, cfg_release_delay = 3, lock and link_state = 10 given in WAIT_LOCK -> phy_reset low after 16 cycles, link_reset low 4 cycles later, buffer_release_n low 4 cycles after lock is seen; link_state = 11 -> status_link_up = 1.
REQ-046 Lock timeout: cfg_timeout = 10, no lock -> BACKOFF after 11 WAIT_LOCK cycles, event_retry pulses once, status_retry_count = 1, PHY_RESET entered 64 cycles later.
REQ-047 Retry exhaustion: cfg_max_retries = 2, lock never given -> 2 event_retry pulses, then FAILED with status_failed = 1 and phy_reset = 1; cfg_enable = 0 -> IDLE with status_failed = 0.
REQ-048 Runtime error: RUNNING with link up, event_unexpected_lane_state_error pulsed -> BACKOFF next edge, buffer_release_n = 1, status_link_up = 0.
REQ-049 Lock loss in RELEASE: cfg_release_delay = 20, all_emb_lock dropped after 5 cycles -> WAIT_LOCK with buffer_release_n still 1.
REQ-050 Abort: cfg_enable dropped mid-PHY_RESET, then resetn pulsed mid-RUNNING -> IDLE on the next edge in each case with all outputs at reset values.
